rom_byte_loader: RTL and testbench

Write-side companion to the synchronous byte-wide ROM blocks. It accepts 32-bit words from the Pocket bridge download path through a valid/ready handshake. Each word in its address window is serialised into four byte writes (big-endian) on the write port of a dual-port RAM that holds ROM contents, which game logic then reads. Words outside the window are consumed and discarded, so several loaders can share one download stream, each with its own BASE_ADDR.

---
 rtl/rom_byte_loader.sv | 147 ++++++++++++++
 tb/tb_rom_byte_loader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_byte_loader.sv
// Purpose: serialise 32-bit download words inside the address window into big-endian byte writes for a ROM RAM.
// Latency: a word accepted at edge k gives its first wr_en at edge k+1 when step_en is high in cycle k+1.
// Backpressure: dl_ready high in IDLE or on the final step_en byte; bytes advance only on step_en cycles.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   dl_valid/dl_ready   : download word handshake; dl_addr is the bridge byte address, dl_data the word
//   dl_end              : one-cycle pulse marking the end of the download stream
//   step_en             : write pacing enable (clock enable of the target RAM)
//   wr_en/wr_addr/wr_data : registered byte write port into the ROM RAM
//   busy, done          : word in flight; sticky end-of-download-and-drained flag
//   byte_count          : bytes written since reset, saturating at 2**ADDR_WIDTH
module rom_byte_loader #(
  parameter int          ADDR_WIDTH = 15,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dl_valid,
  output logic                  dl_ready,
  input  logic [31:0]           dl_addr,
  input  logic [31:0]           dl_data,
  input  logic                  dl_end,
  input  logic                  step_en,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   byte_count
);

  typedef enum logic {IDLE, EMIT} state_t;

  // One bit wider than the address so a 32-bit window size still fits.
  localparam logic [32:0] WIN_SIZE = 33'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                state, state_nxt;
  logic [1:0]            idx;
  logic [31:0]           word_q;
  logic [ADDR_WIDTH-1:0] offset_q;
  logic                  end_pend;

  logic [31:0]           word_addr;
  logic [31:0]           win_off;
  logic                  in_win;
  logic                  xfer;
  logic                  load;
  logic                  emit;
  logic [7:0]            cur_byte;

  // Low two address bits carry no meaning: words are always 4-byte aligned.
  assign word_addr = dl_addr & 32'hFFFF_FFFC;
  assign win_off   = word_addr - BASE_ADDR;
  assign in_win    = (word_addr >= BASE_ADDR) && ({1'b0, win_off} < WIN_SIZE);

  // Ready also opens on the last byte so a following word starts with no bubble.
  assign dl_ready = (state == IDLE) || ((state == EMIT) && (idx == 2'd3) && step_en);
  assign xfer     = dl_valid && dl_ready;

  always_comb begin
    cur_byte = word_q[31:24];
    case (idx)
      2'd0: cur_byte = word_q[31:24];
      2'd1: cur_byte = word_q[23:16];
      2'd2: cur_byte = word_q[15:8];
      2'd3: cur_byte = word_q[7:0];
      default: cur_byte = word_q[31:24];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    emit      = 1'b0;
    case (state)
      IDLE: begin
        // Out-of-window words are taken and silently dropped.
        if (xfer && in_win) begin
          load      = 1'b1;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (step_en) begin
          emit = 1'b1;
          if (idx == 2'd3) begin
            if (xfer && in_win) begin
              load = 1'b1;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= 2'd0;
      word_q     <= 32'd0;
      offset_q   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      end_pend   <= 1'b0;
      byte_count <= '0;
    end else begin
      wr_en <= emit;
      if (emit) begin
        // offset_q is word aligned, so OR-ing the byte index forms the byte address.
        wr_addr <= offset_q | ADDR_WIDTH'(idx);
        wr_data <= cur_byte;
        idx     <= idx + 2'd1;
        if (byte_count != COUNT_MAX) begin
          byte_count <= byte_count + 1'b1;
        end
      end
      // A load on the last byte overrides the wrapping increment above.
      if (load) begin
        word_q   <= dl_data;
        offset_q <= win_off[ADDR_WIDTH-1:0];
        idx      <= 2'd0;
      end
      busy     <= (state_nxt == EMIT);
      end_pend <= end_pend | dl_end;
      // Done only once nothing is held and nothing new is arriving this cycle.
      if (end_pend && (state == IDLE) && !xfer) begin
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_byte_loader.sv
module tb_rom_byte_loader;

  localparam int          AW   = 15;
  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam int          MAXC = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          dl_valid = 1'b0;
  logic          dl_ready;
  logic [31:0]   dl_addr = 32'd0;
  logic [31:0]   dl_data = 32'd0;
  logic          dl_end = 1'b0;
  logic          step_en = 1'b1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic          done;
  logic [AW:0]   byte_count;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  bit toggle = 1'b0;

  rom_byte_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .dl_valid(dl_valid), .dl_ready(dl_ready),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_end(dl_end), .step_en(step_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .done(done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // ---------------- behavioural model: a queue of pending byte writes ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wbyte_t;

  wbyte_t        q[$];
  logic          m_wr_en = 0;
  logic [AW-1:0] m_wr_addr = '0;
  logic [7:0]    m_wr_data = 0;
  int            m_count = 0;
  logic          m_done = 0;
  logic          m_end_pend = 0;

  function automatic bit in_window(input logic [31:0] a);
    logic [63:0] w;
    w = {32'd0, a & 32'hFFFF_FFFC};
    return (w >= {32'd0, BASE}) && (w < {32'd0, BASE} + MAXC);
  endfunction

  // The loader may take a word when no byte would remain pending after this cycle.
  function automatic bit model_ready();
    return (q.size() == 0) || (q.size() == 1 && step_en);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_wr_en = 0; m_wr_addr = '0; m_wr_data = 0;
      m_count = 0; m_done = 0; m_end_pend = 0;
    end else begin
      bit rdy, idle_pre, xf;
      wbyte_t e;
      logic [31:0] off;
      rdy = model_ready();
      idle_pre = (q.size() == 0);
      xf = dl_valid && rdy;
      m_wr_en = 0;
      if (q.size() != 0 && step_en) begin
        e = q.pop_front();
        m_wr_en = 1; m_wr_addr = e.addr; m_wr_data = e.data;
        if (m_count < MAXC) m_count++;
      end
      if (xf && in_window(dl_addr)) begin
        off = (dl_addr & 32'hFFFF_FFFC) - BASE;
        for (int i = 0; i < 4; i++) begin
          e.addr = AW'(off + i);
          e.data = 8'((dl_data >> (24 - 8 * i)) & 32'hFF);
          q.push_back(e);
        end
      end
      if (m_end_pend && idle_pre && !xf) m_done = 1;
      if (dl_end) m_end_pend = 1;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("wr_en", wr_en, m_wr_en);
    chk("wr_addr", wr_addr, m_wr_addr);
    chk("wr_data", wr_data, m_wr_data);
    chk("busy", busy, q.size() != 0);
    chk("done", done, m_done);
    chk("byte_count", byte_count, m_count);
    chk("dl_ready", dl_ready, model_ready());
  end

  // Log of DUT writes, compared against hand-computed literals.
  logic [AW-1:0] log_addr[$];
  logic [7:0]    log_data[$];
  int            log_cyc[$];
  always @(negedge clk) begin
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_cyc.push_back(cyc_n);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (toggle) step_en = ~step_en;
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d);
    int n;
    bit acc;
    n = 0;
    acc = 0;
    #1;
    dl_valid = 1; dl_addr = a; dl_data = d;
    while (!acc && n < 20) begin
      acc = dl_ready;
      cyc();
      n++;
    end
    dl_valid = 0;
    if (!acc) chk("send_accept_timeout", acc, 1);
  endtask

  initial begin
    int b;
    logic [AW-1:0] ea [4];
    logic [7:0]    ed [4];

    // Reset state
    repeat (3) cyc();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_ready", dl_ready, 1);
    reset = 0;
    cyc();

    // Single in-window word
    ea = '{15'h10, 15'h11, 15'h12, 15'h13};
    ed = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send(BASE + 32'h10, 32'hA1B2C3D4);
    chk("t1_wr_en_at_accept", wr_en, 0);
    chk("t1_busy_at_accept", busy, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t1_wr_en", wr_en, 1);
      chk("t1_addr", wr_addr, ea[i]);
      chk("t1_data", wr_data, ed[i]);
    end
    chk("t1_busy_fall", busy, 0);
    chk("t1_count", byte_count, 4);
    cyc();
    chk("t1_idle_wr_en", wr_en, 0);

    // Back-to-back words: 8 consecutive writes at 0..7
    b = log_addr.size();
    send(BASE + 32'h0, 32'h11223344);
    send(BASE + 32'h4, 32'h55667788);
    repeat (5) cyc();
    chk("t2_nwrites", log_addr.size() - b, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t2_addr", log_addr[b + i], AW'(i));
      chk("t2_data", log_data[b + i], 8'(8'h11 * (i + 1)));
      if (i > 0) chk("t2_consecutive", log_cyc[b + i] - log_cyc[b + i - 1], 1);
    end
    chk("t2_count", byte_count, 12);

    // Pacing: step_en alternating
    b = log_addr.size();
    toggle = 1;
    send(BASE + 32'h20, 32'hCAFEBABE);
    repeat (10) cyc();
    toggle = 0;
    step_en = 1;
    chk("t3_nwrites", log_addr.size() - b, 4);
    chk("t3_span", log_cyc[b + 3] - log_cyc[b], 6);
    chk("t3_byte0", log_data[b], 8'hCA);
    chk("t3_byte3", log_data[b + 3], 8'hBE);
    chk("t3_addr3", log_addr[b + 3], 15'h23);

    // Window filtering
    b = log_addr.size();
    send(32'h00FF_FFFC, 32'hEEEEEEEE);
    chk("t4_below_busy", busy, 0);
    repeat (2) cyc();
    chk("t4_below_nowrite", log_addr.size() - b, 0);
    send(32'h0100_7FFC, 32'h01020304);
    repeat (5) cyc();
    chk("t4_top_nwrites", log_addr.size() - b, 4);
    chk("t4_top_addr0", log_addr[b], 15'h7FFC);
    chk("t4_top_addr3", log_addr[b + 3], 15'h7FFF);
    chk("t4_top_data3", log_data[b + 3], 8'h04);
    b = log_addr.size();
    send(32'h0100_8000, 32'hEEEEEEEE);
    repeat (2) cyc();
    chk("t4_above_nowrite", log_addr.size() - b, 0);
    send(BASE + 32'h33, 32'h5A5B5C5D);
    repeat (5) cyc();
    chk("t4_lowbits_addr0", log_addr[b], 15'h30);
    chk("t4_lowbits_data0", log_data[b], 8'h5A);
    chk("t4_count", byte_count, 24);

    // End and done
    send(BASE + 32'h40, 32'h99AABBCC);
    cyc();
    dl_end = 1;
    cyc();
    dl_end = 0;
    chk("t5_done_b1", done, 0);
    cyc();
    chk("t5_done_b2", done, 0);
    cyc();
    chk("t5_last_addr", wr_addr, 15'h43);
    chk("t5_busy_fall", busy, 0);
    chk("t5_done_b3", done, 0);
    cyc();
    chk("t5_done_set", done, 1);
    send(BASE + 32'h44, 32'h01010101);
    repeat (5) cyc();
    chk("t5_done_sticky", done, 1);
    chk("t5_count", byte_count, 32);

    // Reset mid-word
    send(BASE + 32'h50, 32'hDEADBEEF);
    cyc();
    cyc();
    #1;
    reset = 1;
    #1;
    chk("t6_wr_en", wr_en, 0);
    chk("t6_wr_addr", wr_addr, 0);
    chk("t6_wr_data", wr_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_count", byte_count, 0);
    @(posedge clk);
    #1;
    reset = 0;
    #1;
    b = log_addr.size();
    repeat (4) cyc();
    chk("t6_no_writes", log_addr.size() - b, 0);
    send(BASE + 32'h60, 32'h0A0B0C0D);
    repeat (5) cyc();
    chk("t6_new_addr0", log_addr[b], 15'h60);
    chk("t6_new_data0", log_data[b], 8'h0A);
    chk("t6_new_count", byte_count, 4);

    // Saturation of byte_count at 2**AW
    for (int i = 0; i < 8200; i++) send(BASE + 32'((i * 4) % MAXC), 32'(i));
    repeat (6) cyc();
    chk("sat_count", byte_count, MAXC);
    chk("sat_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
